// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types for the load/store unit
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    F_MIS_LD  = 2'd0,
    F_MIS_ST  = 2'd1,
    F_TIMEOUT = 2'd2
  } flt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - extracts and extends a byte/half/word from a bus word
module load_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // pick the addressed lanes and extend to 32 bits
  always_comb begin
    data = shifted;
    case (size)
      MEM_B:   data = is_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data = is_unsigned ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: one valid/ready data-bus transaction at a time
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // counter holds cycles already spent in REQ/WAIT, so the last allowed cycle is BUS_TIMEOUT-1
  localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  logic [7:0]  tmo_cnt_q;
  mem_size_t   size_q;
  logic        unsigned_q;
  logic        store_q;
  logic [1:0]  off_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic        done_q, fault_q;
  flt_t        fault_cause_q;
  logic [31:0] load_data_q;

  mem_size_t   req_size_e;
  logic        accept, misaligned, tmo_hit;
  logic        complete, capture, timeout;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] aligned;

  assign req_size_e  = mem_size_t'(req_size);
  assign accept      = req_valid && (state_q == IDLE);
  assign tmo_hit     = (tmo_cnt_q == TMO_LAST);

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign bus_valid   = (state_q == REQ);
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign load_data   = load_data_q;

  load_aligner u_load_aligner (
    .rdata       (bus_rdata),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .offset      (off_q),
    .data        (aligned)
  );

  // alignment check and store lane replication for the incoming request
  always_comb begin
    misaligned = 1'b0;
    st_wdata   = req_wdata;
    st_wstrb   = 4'b1111;
    case (req_size_e)
      MEM_B: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      MEM_H: begin
        misaligned = req_addr[0];
        st_wdata   = {2{req_wdata[15:0]}};
        st_wstrb   = 4'b0011 << req_addr[1:0];
      end
      default: misaligned = (req_addr[1:0] != 2'b00);
    endcase
    if (!req_store) st_wstrb = 4'b0000;
  end

  // next state; completion takes priority over timeout in the same cycle
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: if (accept && !misaligned) state_d = REQ;
      REQ: begin
        if (bus_ready && (store_q || bus_rvalid)) begin
          complete = 1'b1;
          capture  = !store_q;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (bus_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          complete = 1'b1;
          capture  = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, request capture, timeout counter and registered result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      size_q        <= MEM_B;
      unsigned_q    <= 1'b0;
      store_q       <= 1'b0;
      off_q         <= 2'b00;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= 4'b0000;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= F_MIS_LD;
      load_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= (state_q == IDLE) ? 8'd0 : tmo_cnt_q + 8'd1;
      done_q    <= complete;
      fault_q   <= timeout || (accept && misaligned);
      if (accept && misaligned) begin
        fault_cause_q <= req_store ? F_MIS_ST : F_MIS_LD;
      end else if (timeout) begin
        fault_cause_q <= F_TIMEOUT;
      end
      if (accept && !misaligned) begin
        size_q      <= req_size_e;
        unsigned_q  <= req_unsigned;
        store_q     <= req_store;
        off_q       <= req_addr[1:0];
        bus_we_q    <= req_store;
        bus_addr_q  <= {req_addr[31:2], 2'b00};
        bus_wdata_q <= st_wdata;
        bus_wstrb_q <= st_wstrb;
      end
      if (capture) load_data_q <= aligned;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  load_store_unit #(.BUS_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .load_data(load_data),
    .fault(fault), .fault_cause(fault_cause), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_fault;
    logic [1:0]  cause;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  ev_t  evq[$];
  bus_t bq[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   bv_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compares every completion/fault and bus handshake against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_valid) bv_cnt++;
      if (bus_valid && bus_ready) begin
        if (bq.size() == 0) begin
          chk("unexpected_bus_handshake", 32'd1, 32'd0);
        end else begin
          bus_t b;
          b = bq.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_we", {31'b0, bus_we}, {31'b0, b.we});
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, b.wstrb});
          if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
        end
      end
      if (done || fault) begin
        if (evq.size() == 0) begin
          chk("unexpected_done_fault", {30'b0, done, fault}, 32'd0);
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("event_is_fault", {31'b0, fault}, {31'b0, e.is_fault});
          chk("event_done", {31'b0, done}, {31'b0, !e.is_fault});
          chk("event_cycle", cyc, e.cyc);
          if (e.is_fault) chk("fault_cause", {30'b0, fault_cause}, {30'b0, e.cause});
          else            chk("load_data", load_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic f, input logic [1:0] cause, input logic [31:0] d, input int at);
    ev_t e;
    e.is_fault = f; e.cause = cause; e.data = d; e.cyc = at;
    evq.push_back(e);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
    bus_t b;
    b.addr = a; b.we = we; b.wstrb = s; b.wdata = d;
    bq.push_back(b);
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = d;
  endtask

  // aligned op: ready after rdy_w idle REQ cycles; load response rv_w cycles after ready
  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                        input int rdy_w, input int rv_w,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_bwdata, input logic [31:0] exp_ld, input int exp_lat);
    push_ev(1'b0, 2'd0, exp_ld, cyc + exp_lat);
    push_bus(exp_baddr, st, exp_strb, exp_bwdata);
    drive_req(st, sz, uns, a, d);
    step();
    req_valid = 1'b0;
    repeat (rdy_w) step();
    bus_ready = 1'b1;
    if (!st && rv_w == 0) begin bus_rvalid = 1'b1; bus_rdata = rd; end
    step();
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    if (!st && rv_w > 0) begin
      repeat (rv_w - 1) step();
      bus_rvalid = 1'b1; bus_rdata = rd;
      step();
      bus_rvalid = 1'b0;
    end
  endtask

  task automatic run_mis(input logic st, input logic [1:0] sz, input logic [31:0] a,
                         input logic [1:0] exp_cause);
    int bv0;
    bv0 = bv_cnt;
    push_ev(1'b1, exp_cause, 32'd0, cyc + 1);
    drive_req(st, sz, 1'b0, a, 32'h1234_5678);
    step();
    req_valid = 1'b0;
    step();
    chk("mis_no_bus_valid", bv_cnt, bv0);
    chk("mis_ready_again", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_busy"},        {31'b0, busy},        32'd0);
    chk({tag, "_done"},        {31'b0, done},        32'd0);
    chk({tag, "_fault"},       {31'b0, fault},       32'd0);
    chk({tag, "_bus_valid"},   {31'b0, bus_valid},   32'd0);
    chk({tag, "_bus_we"},      {31'b0, bus_we},      32'd0);
    chk({tag, "_bus_wstrb"},   {28'b0, bus_wstrb},   32'd0);
    chk({tag, "_load_data"},   load_data,            32'd0);
    chk({tag, "_fault_cause"}, {30'b0, fault_cause}, 32'd0);
    chk({tag, "_req_ready"},   {31'b0, req_ready},   32'd1);
  endtask

  initial begin
    int c, bv0;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_reset_vals("reset");

    // SB 0x1003
    run_op(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0,
           32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 2);
    // LH / LHU 0x2002, response one cycle after ready
    run_op(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 0, 1,
           32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001, 3);
    run_op(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0, 1,
           32'h2000, 4'b0000, 32'h0, 32'h0000_8001, 3);
    // misaligned LW and SH
    run_mis(1'b0, 2'd2, 32'h3001, 2'd0);
    run_mis(1'b1, 2'd1, 32'h3003, 2'd1);
    // SH 0x2006, upper half lanes
    run_op(1'b1, 2'd1, 1'b0, 32'h2006, 32'h0000_BEEF, 32'h0, 0, 0,
           32'h2004, 4'b1100, 32'hBEEF_BEEF, 32'h0000_8001, 2);
    // LBU 0x5003 with two ready waits and response two cycles later
    run_op(1'b0, 2'd0, 1'b1, 32'h5003, 32'h0, 32'hC300_0000, 2, 2,
           32'h5000, 4'b0000, 32'h0, 32'h0000_00C3, 6);
    // LB 0x5001 zero-wait, then SW accepted in the done cycle
    run_op(1'b0, 2'd0, 1'b0, 32'h5001, 32'h0, 32'h0000_8000, 0, 0,
           32'h5000, 4'b0000, 32'h0, 32'hFFFF_FF80, 2);
    run_op(1'b1, 2'd2, 1'b0, 32'h5004, 32'hDEAD_BEEF, 32'h0, 0, 0,
           32'h5004, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FF80, 2);

    // timeout: LW 0x4000 with bus_ready held low
    c = cyc;
    bv0 = bv_cnt;
    push_ev(1'b1, 2'd2, 32'h0, c + 9);
    drive_req(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
    step();
    req_valid = 1'b0;
    repeat (8) step();
    chk("tmo_bus_valid_cycles", bv_cnt - bv0, 32'd8);
    chk("tmo_req_ready", {31'b0, req_ready}, 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_rvalid = 1'b0;
    step();
    chk("tmo_late_rvalid_ignored", load_data, 32'hFFFF_FF80);
    chk("tmo_bus_valid_low", {31'b0, bus_valid}, 32'd0);

    // reset while in WAIT, then a late response
    push_bus(32'h6000, 1'b0, 4'b0000, 32'h0);
    drive_req(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
    step();
    req_valid = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk("wait_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h2222_2222;
    chk_reset_vals("wait_reset");
    step();
    bus_rvalid = 1'b0;
    chk_reset_vals("after_late_rvalid");

    for (int i = 0; i < 20 && (evq.size() != 0 || bq.size() != 0); i++) step();
    chk("events_pending", evq.size(), 32'd0);
    chk("bus_pending", bq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
